// File: rtl/baud_pkg.sv
// Shared baud-rate definitions: rate-select enum, rate table and NCO increment helper.
// No logic, constants only.
// Used at elaboration time to build the per-rate increment table.
package baud_pkg;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4,
    BAUD_230400 = 3'd5,
    BAUD_460800 = 3'd6,
    BAUD_921600 = 3'd7
  } baud_sel_e;

  localparam int NUM_RATES = 8;

  localparam longint unsigned BAUD_RATES [NUM_RATES] = '{
    64'd9600, 64'd19200, 64'd38400, 64'd57600,
    64'd115200, 64'd230400, 64'd460800, 64'd921600
  };

  // Rounded NCO step: rate * oversample * 2^acc_w / clk_hz, to nearest integer.
  function automatic longint unsigned calc_incr(
    input longint unsigned rate,
    input longint unsigned os,
    input longint unsigned acc_w,
    input longint unsigned clk_hz
  );
    longint unsigned num;
    num = (rate * os) << acc_w;
    return (num + (clk_hz >> 1)) / clk_hz;
  endfunction

endpackage

// File: rtl/baud_os_cnt.sv
// Oversample phase counter: advances os_phase on each NCO carry, flags bit centre and boundary.
// Strobes are registered, aligned with the os_tick produced from the same carry.
// clear zeroes phase and strobes; hold freezes the phase and suppresses strobes.
module baud_os_cnt #(
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          hold,
  input  logic                          step,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
  output logic                          mid_tick,
  output logic                          bit_tick
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] MID_PRE = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] LAST    = PW'(OVERSAMPLE - 1);

  logic adv;

  assign adv = step & ~hold;

  // Phase register; the centre/boundary strobes fire on the step that lands on OVERSAMPLE/2 or wraps to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_phase <= '0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else if (clear) begin
      os_phase <= '0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      mid_tick <= adv && (os_phase == MID_PRE);
      bit_tick <= adv && (os_phase == LAST);
      if (adv) begin
        os_phase <= os_phase + 1'b1;
      end
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-NCO baud generator producing oversample, bit-centre and bit-boundary ticks.
// Ticks are registered one cycle after the accumulator carry; first tick ceil(2^ACC_W/INCR)+1 cycles after a clear.
// en=0 freezes NCO and phase; restart or a new baud_sel clears both regardless of en.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          restart,
  input  logic [2:0]                    baud_sel,
  output logic                          os_tick,
  output logic                          mid_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
  output logic                          sel_chg
);

  if (OVERSAMPLE < 4 || OVERSAMPLE > 64 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
    $error("baud_gen_frac: OVERSAMPLE must be a power of two in 4..64");
  end

  if (ACC_W < 16 || ACC_W > 32) begin : g_bad_accw
    $error("baud_gen_frac: ACC_W must be in 16..32");
  end

  // Per-rate increments are fixed at elaboration; an increment at or above half the
  // accumulator range would make tick spacing collapse to one or two cycles.
  logic [ACC_W-1:0] incr_tab [NUM_RATES];

  for (genvar k = 0; k < NUM_RATES; k++) begin : g_incr
    localparam longint unsigned INCR_K =
      calc_incr(BAUD_RATES[k], 64'(OVERSAMPLE), 64'(ACC_W), 64'(CLK_HZ));
    if (INCR_K == 64'd0 || INCR_K >= (64'd1 << (ACC_W - 1))) begin : g_bad_incr
      $error("baud_gen_frac: increment out of range for rate index %0d", k);
    end
    assign incr_tab[k] = INCR_K[ACC_W-1:0];
  end

  baud_sel_e        sel_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] incr;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             init_q;
  logic             chg;
  logic             clear;

  assign incr  = incr_tab[sel_q];
  assign sum   = {1'b0, acc} + {1'b0, incr};
  assign carry = sum[ACC_W];
  // The first cycle after reset adopts baud_sel silently instead of reporting a change.
  assign chg   = ~init_q & (baud_sel != sel_q);
  assign clear = init_q | restart | chg;

  // Accumulator, rate-select capture and registered os_tick / sel_chg strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      sel_q   <= BAUD_9600;
      init_q  <= 1'b1;
      os_tick <= 1'b0;
      sel_chg <= 1'b0;
    end else begin
      init_q  <= 1'b0;
      sel_q   <= baud_sel_e'(baud_sel);
      sel_chg <= chg;
      os_tick <= en & carry & ~clear;
      if (clear) begin
        acc <= '0;
      end else if (en) begin
        acc <= sum[ACC_W-1:0];
      end
    end
  end

  baud_os_cnt #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_os_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .hold     (~en),
    .step     (carry),
    .os_phase (os_phase),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );

endmodule

// File: tb/tb_baud_gen_frac.sv
`timescale 1ns/1ps
// Bench for baud_gen_frac at default parameters: directed scenarios plus a randomized run,
// all checked cycle by cycle against an arithmetic model of the tick timing.
module tb_baud_gen_frac;
  import baud_pkg::*;

  localparam longint unsigned OSL   = 64'd16;
  localparam longint unsigned MOD   = 64'd1 << 24;
  localparam longint unsigned CLKHZ = 64'd100_000_000;
  localparam longint unsigned RATES [8] = '{
    64'd9600, 64'd19200, 64'd38400, 64'd57600,
    64'd115200, 64'd230400, 64'd460800, 64'd921600
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       restart = 1'b0;
  logic [2:0] baud_sel = 3'd0;
  logic       os_tick, mid_tick, bit_tick, sel_chg;
  logic [3:0] os_phase;

  int nchk = 0;
  int nbad = 0;

  baud_gen_frac #(
    .CLK_HZ(100_000_000),
    .OVERSAMPLE(16),
    .ACC_W(24)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .restart  (restart),
    .baud_sel (baud_sel),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick),
    .os_phase (os_phase),
    .sel_chg  (sel_chg)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Tick timing: after a clear, the n-th enabled cycle emits a tick exactly when
  // floor(n*INCR/2^24) steps up. Phase is the number of ticks since the clear, mod 16.
  bit              m_first;
  int              m_sel;
  longint unsigned m_adds;
  longint unsigned m_ticks;
  logic            e_os, e_mid, e_bit, e_chg;
  logic [3:0]      e_phase;

  function automatic longint unsigned ref_incr(input int s);
    return (RATES[s] * OSL * MOD + CLKHZ / 2) / CLKHZ;
  endfunction

  function automatic longint unsigned ref_ceil(input int s);
    return (MOD + ref_incr(s) - 1) / ref_incr(s);
  endfunction

  function automatic void model_reset();
    m_first = 1'b1; m_sel = 0; m_adds = 0; m_ticks = 0;
    e_os = 1'b0; e_mid = 1'b0; e_bit = 1'b0; e_chg = 1'b0; e_phase = 4'd0;
  endfunction

  function automatic void model_step();
    longint unsigned inc;
    if (rst) begin
      model_reset();
    end else if (m_first) begin
      m_first = 1'b0; m_sel = int'(baud_sel); m_adds = 0; m_ticks = 0;
      e_os = 1'b0; e_mid = 1'b0; e_bit = 1'b0; e_chg = 1'b0;
    end else begin
      e_chg = (int'(baud_sel) != m_sel);
      e_os = 1'b0; e_mid = 1'b0; e_bit = 1'b0;
      if (e_chg || restart) begin
        m_sel = int'(baud_sel); m_adds = 0; m_ticks = 0;
      end else if (en) begin
        inc = ref_incr(m_sel);
        m_adds++;
        if ((m_adds * inc) / MOD != ((m_adds - 1) * inc) / MOD) begin
          m_ticks++;
          e_os  = 1'b1;
          e_bit = (m_ticks % OSL == 0);
          e_mid = (m_ticks % OSL == OSL / 2);
        end
      end
    end
    e_phase = 4'(m_ticks % OSL);
  endfunction

  function automatic logic [7:0] obs_v();
    return {os_tick, mid_tick, bit_tick, sel_chg, os_phase};
  endfunction

  function automatic logic [7:0] exp_v();
    return {e_os, e_mid, e_bit, e_chg, e_phase};
  endfunction

  // One clock: the model sees the same inputs as the DUT edge, outputs are read 1ns later.
  task automatic tick_clk();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int first;
    rst = 1'b1; en = 1'b1; restart = 1'b0; baud_sel = 3'd4;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      nchk++;
      if (obs_v() !== 8'h00) begin
        nbad++; $display("FAIL reset_hold got=%h want=00", obs_v());
      end
    end
    rst = 1'b0;
    first = -1;
    for (int i = 0; i < 200; i++) begin
      tick_clk();
      nchk++;
      if (obs_v() !== exp_v()) begin
        nbad++; $display("FAIL post_reset i=%0d got=%h want=%h", i, obs_v(), exp_v());
      end
      if (os_tick && first < 0) first = i;
    end
    nchk++;
    if (longint'(first) != longint'(ref_ceil(4))) begin
      nbad++; $display("FAIL reset_first_tick got=%0d want=%0d", first, ref_ceil(4));
    end
  endtask

  task automatic test_incr_table();
    longint unsigned v;
    v = calc_incr(64'd9600, 64'd16, 64'd24, 64'd100_000_000);
    nchk++;
    if (v != 64'd25770) begin nbad++; $display("FAIL incr_9600 got=%0d want=25770", v); end
    v = calc_incr(64'd115200, 64'd16, 64'd24, 64'd100_000_000);
    nchk++;
    if (v != 64'd309238) begin nbad++; $display("FAIL incr_115200 got=%0d want=309238", v); end
    for (int k = 0; k < 8; k++) begin
      v = calc_incr(BAUD_RATES[k], 64'd16, 64'd24, 64'd100_000_000);
      nchk++;
      if (v != ref_incr(k)) begin
        nbad++; $display("FAIL incr_tab k=%0d got=%0d want=%0d", k, v, ref_incr(k));
      end
    end
  endtask

  task automatic test_rate(input logic [2:0] sel, input int ncyc, input int lo, input int hi,
                           input string name);
    int last, ntick, nbit, first;
    longint unsigned want_ticks;
    baud_sel = sel; en = 1'b1; restart = 1'b1;
    tick_clk();
    restart = 1'b0;
    nchk++;
    if (obs_v() !== exp_v()) begin
      nbad++; $display("FAIL %s_clear got=%h want=%h", name, obs_v(), exp_v());
    end
    last = -1; ntick = 0; nbit = 0; first = -1;
    for (int c = 1; c <= ncyc; c++) begin
      tick_clk();
      nchk++;
      if (obs_v() !== exp_v()) begin
        nbad++; $display("FAIL %s c=%0d got=%h want=%h", name, c, obs_v(), exp_v());
      end
      if (os_tick) begin
        ntick++;
        if (first < 0) first = c;
        if (last >= 0) begin
          nchk++;
          if (c - last != lo && c - last != hi) begin
            nbad++; $display("FAIL %s_spacing got=%0d want=%0d|%0d", name, c - last, lo, hi);
          end
        end
        last = c;
      end
      if (bit_tick) nbit++;
    end
    want_ticks = longint'(ncyc) * ref_incr(int'(sel)) / MOD;
    nchk++;
    if (longint'(ntick) != longint'(want_ticks)) begin
      nbad++; $display("FAIL %s_os_count got=%0d want=%0d", name, ntick, want_ticks);
    end
    nchk++;
    if (longint'(nbit) != longint'(want_ticks / OSL)) begin
      nbad++; $display("FAIL %s_bit_count got=%0d want=%0d", name, nbit, want_ticks / OSL);
    end
    nchk++;
    if (longint'(first) != longint'(ref_ceil(int'(sel)))) begin
      nbad++; $display("FAIL %s_first got=%0d want=%0d", name, first, ref_ceil(int'(sel)));
    end
  endtask

  task automatic test_en_hold();
    int ecount, waited;
    logic [3:0] frozen;
    bit got;
    baud_sel = 3'd0; en = 1'b1; restart = 1'b1;
    tick_clk();
    restart = 1'b0;
    ecount = 0; waited = 0;
    while (os_phase != 4'd5 && waited < 8000) begin
      tick_clk(); waited++; ecount++;
      if (os_tick) ecount = 0;
      nchk++;
      if (obs_v() !== exp_v()) begin
        nbad++; $display("FAIL enhold_run got=%h want=%h", obs_v(), exp_v());
      end
    end
    nchk++;
    if (os_phase !== 4'd5) begin nbad++; $display("FAIL enhold_reach got=%0d want=5", os_phase); end
    repeat ($urandom_range(50, 500)) begin
      tick_clk(); ecount++;
      if (os_tick) ecount = 0;
      nchk++;
      if (obs_v() !== exp_v()) begin
        nbad++; $display("FAIL enhold_mid got=%h want=%h", obs_v(), exp_v());
      end
    end
    frozen = os_phase;
    en = 1'b0;
    repeat (500) begin
      tick_clk();
      nchk++;
      if ({os_tick, mid_tick, bit_tick} !== 3'b000 || os_phase !== frozen) begin
        nbad++; $display("FAIL enhold_frozen ticks=%b phase=%0d want=000 phase=%0d",
                         {os_tick, mid_tick, bit_tick}, os_phase, frozen);
      end
      nchk++;
      if (obs_v() !== exp_v()) begin
        nbad++; $display("FAIL enhold_model got=%h want=%h", obs_v(), exp_v());
      end
    end
    en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 800 && !got; i++) begin
      tick_clk(); ecount++;
      nchk++;
      if (obs_v() !== exp_v()) begin
        nbad++; $display("FAIL enhold_resume got=%h want=%h", obs_v(), exp_v());
      end
      if (os_tick) begin
        got = 1'b1;
        nchk++;
        if (ecount != 651 && ecount != 652) begin
          nbad++; $display("FAIL enhold_spacing got=%0d want=651|652", ecount);
        end
      end
    end
    nchk++;
    if (!got) begin nbad++; $display("FAIL enhold_timeout got=no_tick want=tick"); end
  endtask

  task automatic test_restart();
    int waited, first;
    baud_sel = 3'd0; en = 1'b1; restart = 1'b1;
    tick_clk();
    restart = 1'b0;
    waited = 0;
    while (os_phase != 4'd9 && waited < 8000) begin
      tick_clk(); waited++;
      nchk++;
      if (obs_v() !== exp_v()) begin
        nbad++; $display("FAIL restart_run got=%h want=%h", obs_v(), exp_v());
      end
    end
    nchk++;
    if (os_phase !== 4'd9) begin nbad++; $display("FAIL restart_reach got=%0d want=9", os_phase); end
    restart = 1'b1;
    tick_clk();
    restart = 1'b0;
    nchk++;
    if (os_phase !== 4'd0 || {os_tick, mid_tick, bit_tick} !== 3'b000) begin
      nbad++; $display("FAIL restart_clear phase=%0d ticks=%b want=0 000",
                       os_phase, {os_tick, mid_tick, bit_tick});
    end
    first = -1;
    for (int c = 1; c <= 700; c++) begin
      tick_clk();
      nchk++;
      if (obs_v() !== exp_v()) begin
        nbad++; $display("FAIL restart_after c=%0d got=%h want=%h", c, obs_v(), exp_v());
      end
      if (os_tick && first < 0) first = c;
    end
    nchk++;
    if (first + 1 != 653) begin
      nbad++; $display("FAIL restart_first_cycle got=%0d want=653", first + 1);
    end
  endtask

  task automatic test_sel_change();
    int waited, first, nchg;
    baud_sel = 3'd0; en = 1'b1; restart = 1'b1;
    tick_clk();
    restart = 1'b0;
    waited = 0;
    while (os_phase != 4'd3 && waited < 4000) begin
      tick_clk(); waited++;
      nchk++;
      if (obs_v() !== exp_v()) begin
        nbad++; $display("FAIL selchg_run got=%h want=%h", obs_v(), exp_v());
      end
    end
    repeat ($urandom_range(1, 300)) begin
      tick_clk();
      nchk++;
      if (obs_v() !== exp_v()) begin
        nbad++; $display("FAIL selchg_mid got=%h want=%h", obs_v(), exp_v());
      end
    end
    baud_sel = 3'd4;
    tick_clk();
    nchk++;
    if (sel_chg !== 1'b1 || os_phase !== 4'd0 || os_tick !== 1'b0) begin
      nbad++; $display("FAIL selchg_pulse chg=%b phase=%0d tick=%b want=1 0 0",
                       sel_chg, os_phase, os_tick);
    end
    nchg = 1; first = -1;
    for (int c = 1; c <= 120; c++) begin
      tick_clk();
      nchk++;
      if (obs_v() !== exp_v()) begin
        nbad++; $display("FAIL selchg_after c=%0d got=%h want=%h", c, obs_v(), exp_v());
      end
      if (sel_chg) nchg++;
      if (os_tick && first < 0) first = c;
    end
    nchk++;
    if (nchg != 1) begin nbad++; $display("FAIL selchg_once got=%0d want=1", nchg); end
    nchk++;
    if (first != 55) begin nbad++; $display("FAIL selchg_first got=%0d want=55", first); end
    // A rate change still applies while disabled.
    en = 1'b0; baud_sel = 3'd1;
    tick_clk();
    nchk++;
    if (sel_chg !== 1'b1 || os_phase !== 4'd0) begin
      nbad++; $display("FAIL selchg_en_low chg=%b phase=%0d want=1 0", sel_chg, os_phase);
    end
    en = 1'b1;
  endtask

  task automatic test_rst_mid();
    int first, nchg;
    baud_sel = 3'd6; en = 1'b1; restart = 1'b1;
    tick_clk();
    restart = 1'b0;
    repeat ($urandom_range(100, 400)) begin
      tick_clk();
      nchk++;
      if (obs_v() !== exp_v()) begin
        nbad++; $display("FAIL rstmid_run got=%h want=%h", obs_v(), exp_v());
      end
    end
    #($urandom_range(1, 7));
    rst = 1'b1;
    #1;
    nchk++;
    if (obs_v() !== 8'h00) begin nbad++; $display("FAIL rstmid_async got=%h want=00", obs_v()); end
    model_reset();
    repeat (3) begin
      tick_clk();
      nchk++;
      if (obs_v() !== 8'h00) begin nbad++; $display("FAIL rstmid_hold got=%h want=00", obs_v()); end
    end
    rst = 1'b0;
    first = -1; nchg = 0;
    for (int i = 0; i < 300; i++) begin
      tick_clk();
      nchk++;
      if (obs_v() !== exp_v()) begin
        nbad++; $display("FAIL rstmid_after i=%0d got=%h want=%h", i, obs_v(), exp_v());
      end
      if (sel_chg) nchg++;
      if (os_tick && first < 0) first = i;
    end
    nchk++;
    if (nchg != 0) begin nbad++; $display("FAIL rstmid_selchg got=%0d want=0", nchg); end
    nchk++;
    if (longint'(first) != longint'(ref_ceil(6))) begin
      nbad++; $display("FAIL rstmid_first got=%0d want=%0d", first, ref_ceil(6));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8000; i++) begin
      en      = ($urandom_range(0, 7) != 0);
      restart = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 699) == 0) baud_sel = 3'($urandom_range(4, 7));
      tick_clk();
      nchk++;
      if (obs_v() !== exp_v()) begin
        nbad++; $display("FAIL random i=%0d got=%h want=%h", i, obs_v(), exp_v());
      end
    end
    restart = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_incr_table();
    test_rate(3'd0, 22000, 651, 652, "rate0");
    test_rate(3'd4, 15000, 54, 55, "rate4");
    test_en_hold();
    test_restart();
    test_sel_change();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, meaning the system clock frequency in Hz.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, meaning oversample ticks per bit; it SHALL be a power of two in the range 4..64.
REQ-003 The block SHALL have parameter ACC_W, default 24, meaning the phase-accumulator width in bits; it SHALL be in the range 16..32.
REQ-004 The block SHALL have port clk, input, 1 bit, the system clock; all logic SHALL be rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit; when low, the block holds all state and produces no ticks.
REQ-007 The block SHALL have port restart, input, 1 bit, a synchronous one-cycle resynchronisation request (used at RX start-bit detection).
REQ-008 The block SHALL have port baud_sel, input, 3 bits, the rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5=230400, 6=460800, 7=921600.
REQ-009 The block SHALL have port os_tick, output, 1 bit, a one-cycle pulse at OVERSAMPLE x baud rate.
REQ-010 The block SHALL have port mid_tick, output, 1 bit, a one-cycle pulse at the bit centre.
REQ-011 The block SHALL have port bit_tick, output, 1 bit, a one-cycle pulse at the bit boundary.
REQ-012 The block SHALL have port os_phase, output, $clog2(OVERSAMPLE) bits, the current oversample index within the bit.
REQ-013 The block SHALL have port sel_chg, output, 1 bit, a one-cycle pulse when a new baud_sel value has been applied.

Function
REQ-014 Rate generation SHALL use a fractional NCO: on each enabled cycle, acc <= acc + INCR[sel_q], modulo 2^ACC_W.
REQ-015 INCR[k] SHALL equal round(rate_k x OVERSAMPLE x 2^ACC_W / CLK_HZ) and SHALL be computed at elaboration; with the default parameters, INCR[0]=25770 and INCR[4]=309238.
REQ-016 os_tick SHALL be registered and SHALL assert in the cycle after the accumulator addition carries out of ACC_W bits, giving a latency of one clock from the carry.
REQ-017 The spacing between os_ticks SHALL be floor(2^ACC_W/INCR) or ceil(2^ACC_W/INCR) cycles, with no other values permitted.
REQ-018 os_phase SHALL increment by 1 on each os_tick and SHALL wrap from OVERSAMPLE-1 to 0.
REQ-019 bit_tick SHALL assert together with the os_tick on which os_phase wraps to 0.
REQ-020 mid_tick SHALL assert together with the os_tick on which os_phase becomes OVERSAMPLE/2.
REQ-021 When en=0, acc and os_phase SHALL hold, and os_tick, mid_tick and bit_tick SHALL be 0 in the following cycle.
REQ-022 On restart=1, acc and os_phase SHALL clear to 0, and no tick of any kind SHALL be emitted in the following cycle.
REQ-023 restart SHALL take priority over en and over accumulation.
REQ-024 baud_sel SHALL be captured into sel_q every cycle.
REQ-025 When baud_sel differs from sel_q, the block SHALL load the new value, clear acc and os_phase exactly as for restart, and pulse sel_chg in the following cycle.
REQ-026 A rate change SHALL act regardless of the state of en.
REQ-027 When a restart and a baud_sel change occur in the same cycle, the block SHALL perform a single clear and SHALL pulse sel_chg.
REQ-028 After a reset, restart or rate change, the first os_tick SHALL arrive at cycle ceil(2^ACC_W/INCR)+1.
REQ-029 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-030 Elaboration SHALL fail (via $error) if OVERSAMPLE or ACC_W is outside its allowed range, or if any INCR is 0 or at least 2^(ACC_W-1).

Reset
REQ-031 While rst=1, acc, os_phase and sel_q SHALL be 0, and os_tick, mid_tick, bit_tick and sel_chg SHALL be 0.
REQ-032 After rst deasserts, sel_q SHALL adopt baud_sel without pulsing sel_chg in the first cycle.
REQ-033 An rst asserted mid-bit SHALL abort the bit immediately, with no partial tick emitted.

Structure
REQ-034 A shared package baud_pkg SHALL hold the rate table (8 entries), the constant function computing INCR, and the rate-select enum type.
REQ-035 One sub-module, baud_os_cnt, SHALL be used; it is the os_phase counter that generates mid_tick and bit_tick from os_tick with clear and hold inputs.
REQ-036 The NCO and select-change logic SHALL reside in baud_gen_frac.

Verification
REQ-037 The bench SHALL cover: defaults, baud_sel=0, en=1 for 1,000,000 cycles -> exactly 1536 os_ticks and 96 bit_ticks; every os_tick spacing is 651 or 652.
REQ-038 The bench SHALL cover: baud_sel=4 for 1,000,000 cycles -> 18432 os_ticks, with spacings of 54 or 55 only.
REQ-039 The bench SHALL cover: en low for 500 cycles mid-bit -> no ticks, os_phase frozen; after re-enable, the next os_tick arrives within the remaining period.
REQ-040 The bench SHALL cover: restart pulse at os_phase=9 -> os_phase=0 next cycle, and the first os_tick at cycle 653 after the restart.
REQ-041 The bench SHALL cover: baud_sel changed 0->4 mid-bit -> sel_chg pulses once, acc cleared, and the first os_tick 55 cycles later.
REQ-042 The bench SHALL cover: rst asserted mid-bit at an arbitrary cycle -> all outputs 0 asynchronously; after release, no sel_chg pulse and normal cadence resumes.
